// File: rtl/dmx_pkg.sv
// dmx_pkg: shared definitions for the DMX512 slot receiver.
//   dmx_state_t            receiver state encoding
//   DMX_MAX_SLOTS          slots in a full DMX512 packet
//   DMX_START_CODE_DIMMER  start code of a standard dimmer packet
package dmx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BREAK = 3'd1,
    ST_START = 3'd2,
    ST_SLOTS = 3'd3,
    ST_SKIP  = 3'd4
  } dmx_state_t;

  localparam int         DMX_MAX_SLOTS         = 512;
  localparam logic [7:0] DMX_START_CODE_DIMMER = 8'h00;

endpackage

// File: rtl/dmx_rx_if.sv
// dmx_rx_if: byte stream from the UART and slot write bus to the slot store.
//   rx_data / rx_data_strobe / rx_break_detect : UART -> receiver
//   slot_addr / slot_data / slot_we            : receiver -> slot store
// master = parent side (UART + store), slave = dmx_rx.
interface dmx_rx_if;
  logic [7:0] rx_data;
  logic       rx_data_strobe;
  logic       rx_break_detect;
  logic [8:0] slot_addr;
  logic [7:0] slot_data;
  logic       slot_we;

  modport master (
    output rx_data, rx_data_strobe, rx_break_detect,
    input  slot_addr, slot_data, slot_we
  );

  modport slave (
    input  rx_data, rx_data_strobe, rx_break_detect,
    output slot_addr, slot_data, slot_we
  );
endinterface

// File: rtl/dmx_rx.sv
// dmx_rx: DMX512 frame receiver. Tracks break / start code / slots from a
// UART byte stream and writes the slots that fall inside a WINDOW-slot
// window starting at base_addr.
//   CLK_40            system clock (40 MHz)
//   reset             synchronous, active-high reset
//   bus (slave)       UART byte stream in, slot write bus out
//   base_addr         first slot of the window (latched at start code)
//   frame_done        one-cycle pulse at end of a dimmer frame
//   frame_slot_count  slots received in the last completed frame
//   start_code        start code of the most recent packet
//   signal_valid      a valid frame has completed and no timeout since
module dmx_rx
  import dmx_pkg::*;
#(
  parameter int WINDOW         = 256,
  parameter int TIMEOUT_CYCLES = 40000000,
  parameter int TIMEOUT_WIDTH  = 26
) (
  input  logic         CLK_40,
  input  logic         reset,
  dmx_rx_if.slave      bus,
  input  logic [8:0]   base_addr,
  output logic         frame_done,
  output logic [9:0]   frame_slot_count,
  output logic [7:0]   start_code,
  output logic         signal_valid
);

  dmx_state_t               state_r;
  logic [9:0]               slot_index_r;
  logic [8:0]               base_r;
  logic [TIMEOUT_WIDTH-1:0] timeout_r;
  logic [8:0]               slot_addr_r;
  logic [7:0]               slot_data_r;
  logic                     slot_we_r;
  logic                     frame_done_r;
  logic [9:0]               frame_slot_count_r;
  logic [7:0]               start_code_r;
  logic                     signal_valid_r;
  logic                     timeout_hit_s;

  // Window test in 11 bits so base+WINDOW past 511 clips instead of wrapping.
  function automatic logic in_window(input logic [9:0] idx, input logic [8:0] base);
    logic [10:0] rel;
    rel = {1'b0, idx} - {2'b00, base};
    return (idx >= {1'b0, base}) && (rel < 11'(WINDOW)) && (idx <= 10'd511);
  endfunction

  // A strobe in the same cycle counts as activity, so it can never time out.
  assign timeout_hit_s = (state_r != ST_IDLE) && !bus.rx_data_strobe &&
                         (timeout_r == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Receiver FSM, timeout counter and registered outputs.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state_r            <= ST_IDLE;
      slot_index_r       <= 10'd0;
      base_r             <= 9'd0;
      timeout_r          <= '0;
      slot_addr_r        <= 9'd0;
      slot_data_r        <= 8'd0;
      slot_we_r          <= 1'b0;
      frame_done_r       <= 1'b0;
      frame_slot_count_r <= 10'd0;
      start_code_r       <= 8'd0;
      signal_valid_r     <= 1'b0;
    end else begin
      slot_we_r    <= 1'b0;
      frame_done_r <= 1'b0;
      if (bus.rx_break_detect) begin
        // Break wins over any coincident byte; closes an open dimmer frame.
        if (state_r == ST_SLOTS && slot_index_r != 10'd0) begin
          frame_done_r       <= 1'b1;
          frame_slot_count_r <= slot_index_r;
          signal_valid_r     <= 1'b1;
        end else begin
          frame_done_r <= 1'b0;
        end
        state_r   <= ST_BREAK;
        timeout_r <= '0;
      end else if (timeout_hit_s) begin
        // A partial frame still reports, but the link is declared lost.
        if (state_r == ST_SLOTS && slot_index_r != 10'd0) begin
          frame_done_r       <= 1'b1;
          frame_slot_count_r <= slot_index_r;
        end else begin
          frame_done_r <= 1'b0;
        end
        signal_valid_r <= 1'b0;
        state_r        <= ST_IDLE;
        timeout_r      <= '0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            timeout_r <= '0;
          end
          ST_BREAK: begin
            state_r   <= ST_START;
            timeout_r <= '0;
          end
          ST_START: begin
            if (bus.rx_data_strobe) begin
              start_code_r <= bus.rx_data;
              timeout_r    <= '0;
              if (bus.rx_data == DMX_START_CODE_DIMMER) begin
                state_r      <= ST_SLOTS;
                slot_index_r <= 10'd0;
                base_r       <= base_addr;
              end else begin
                state_r <= ST_SKIP;
              end
            end else begin
              timeout_r <= timeout_r + 1'b1;
            end
          end
          ST_SLOTS: begin
            if (bus.rx_data_strobe) begin
              timeout_r    <= '0;
              slot_index_r <= slot_index_r + 10'd1;
              if (in_window(slot_index_r, base_r)) begin
                slot_we_r   <= 1'b1;
                slot_addr_r <= 9'(slot_index_r - {1'b0, base_r});
                slot_data_r <= bus.rx_data;
              end else begin
                slot_we_r <= 1'b0;
              end
              if (slot_index_r == 10'(DMX_MAX_SLOTS - 1)) begin
                frame_done_r       <= 1'b1;
                frame_slot_count_r <= 10'(DMX_MAX_SLOTS);
                signal_valid_r     <= 1'b1;
                slot_index_r       <= 10'd0;
                state_r            <= ST_IDLE;
              end else begin
                frame_done_r <= 1'b0;
              end
            end else begin
              timeout_r <= timeout_r + 1'b1;
            end
          end
          ST_SKIP: begin
            if (bus.rx_data_strobe) begin
              timeout_r <= '0;
            end else begin
              timeout_r <= timeout_r + 1'b1;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            timeout_r <= '0;
          end
        endcase
      end
    end
  end

  assign bus.slot_addr    = slot_addr_r;
  assign bus.slot_data    = slot_data_r;
  assign bus.slot_we      = slot_we_r;
  assign frame_done       = frame_done_r;
  assign frame_slot_count = frame_slot_count_r;
  assign start_code       = start_code_r;
  assign signal_valid     = signal_valid_r;

endmodule

// File: tb/tb_dmx_rx.sv
// tb_dmx_rx: directed bench for dmx_rx with hand-computed expectations.
module tb_dmx_rx;
  localparam int WINDOW = 256;
  localparam int TO     = 1000;

  logic       CLK_40 = 1'b0;
  logic       reset;
  logic [8:0] base_addr;
  logic       frame_done;
  logic [9:0] frame_slot_count;
  logic [7:0] start_code;
  logic       signal_valid;

  dmx_rx_if bus();

  dmx_rx #(.WINDOW(WINDOW), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(26)) dut (
    .CLK_40           (CLK_40),
    .reset            (reset),
    .bus              (bus),
    .base_addr        (base_addr),
    .frame_done       (frame_done),
    .frame_slot_count (frame_slot_count),
    .start_code       (start_code),
    .signal_valid     (signal_valid)
  );

  always #5 CLK_40 = ~CLK_40;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor: counters only ever grow; tests compare deltas.
  int         wr_cnt = 0;
  int         wr_bad = 0;
  int         fd_cnt = 0;
  int         dbl_cnt = 0;
  logic [8:0] last_addr = 9'd0;
  logic       prev_we = 1'b0;
  logic       prev_fd = 1'b0;

  always @(negedge CLK_40) begin
    if (bus.slot_we) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= bus.slot_addr;
      // Each slot byte carries its slot index, so data = base + addr.
      if (bus.slot_data != 8'(10'(base_addr) + 10'(bus.slot_addr)))
        wr_bad <= wr_bad + 1;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if ((bus.slot_we && prev_we) || (frame_done && prev_fd)) dbl_cnt <= dbl_cnt + 1;
    prev_we <= bus.slot_we;
    prev_fd <= frame_done;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data        = b;
    bus.rx_data_strobe = 1'b1;
    @(posedge CLK_40); #1;
    bus.rx_data_strobe = 1'b0;
    repeat (2) @(posedge CLK_40);
    #1;
  endtask

  task automatic do_break();
    bus.rx_break_detect = 1'b1;
    repeat (4) @(posedge CLK_40);
    #1;
    bus.rx_break_detect = 1'b0;
    @(posedge CLK_40); #1;
  endtask

  task automatic send_slots(input int n);
    for (int i = 0; i < n; i++) send_byte(8'(i));
  endtask

  int w0, f0, n_fall;

  initial begin
    reset               = 1'b1;
    base_addr           = 9'd0;
    bus.rx_data         = 8'd0;
    bus.rx_data_strobe  = 1'b0;
    bus.rx_break_detect = 1'b0;
    repeat (3) @(posedge CLK_40);
    #1;
    check_val("rst_we",   32'(bus.slot_we), 32'd0);
    check_val("rst_addr", 32'(bus.slot_addr), 32'd0);
    check_val("rst_data", 32'(bus.slot_data), 32'd0);
    check_val("rst_fd",   32'(frame_done), 32'd0);
    check_val("rst_fsc",  32'(frame_slot_count), 32'd0);
    check_val("rst_sc",   32'(start_code), 32'd0);
    check_val("rst_sv",   32'(signal_valid), 32'd0);
    reset = 1'b0;
    @(posedge CLK_40); #1;

    // Full frame, window 0..255.
    w0 = wr_cnt; f0 = fd_cnt;
    do_break();
    send_byte(8'h00);
    send_slots(512);
    check_val("full_wr",   32'(wr_cnt - w0), 32'd256);
    check_val("full_data", 32'(wr_bad), 32'd0);
    check_val("full_last", 32'(last_addr), 32'd255);
    check_val("full_fd",   32'(fd_cnt - f0), 32'd1);
    check_val("full_fsc",  32'(frame_slot_count), 32'd512);
    check_val("full_sv",   32'(signal_valid), 32'd1);

    // Window clipped at slot 511: slots 400..511 only.
    base_addr = 9'd400;
    w0 = wr_cnt; f0 = fd_cnt;
    do_break();
    send_byte(8'h00);
    send_slots(512);
    check_val("clip_wr",   32'(wr_cnt - w0), 32'd112);
    check_val("clip_data", 32'(wr_bad), 32'd0);
    check_val("clip_last", 32'(last_addr), 32'd111);
    check_val("clip_fd",   32'(fd_cnt - f0), 32'd1);
    check_val("clip_fsc",  32'(frame_slot_count), 32'd512);

    // Non-dimmer start code is recorded and its payload ignored.
    base_addr = 9'd0;
    w0 = wr_cnt; f0 = fd_cnt;
    do_break();
    send_byte(8'h17);
    send_slots(10);
    check_val("skip_sc", 32'(start_code), 32'h17);
    check_val("skip_wr", 32'(wr_cnt - w0), 32'd0);
    check_val("skip_fd", 32'(fd_cnt - f0), 32'd0);

    // Short frame closed by a break that swallows a coincident byte.
    w0 = wr_cnt; f0 = fd_cnt;
    do_break();
    send_byte(8'h00);
    send_slots(24);
    bus.rx_break_detect = 1'b1;
    bus.rx_data         = 8'hAA;
    bus.rx_data_strobe  = 1'b1;
    @(posedge CLK_40); #1;
    bus.rx_data_strobe = 1'b0;
    check_val("brk_fd_now", 32'(frame_done), 32'd1);
    check_val("brk_fsc",    32'(frame_slot_count), 32'd24);
    repeat (4) @(posedge CLK_40);
    #1;
    check_val("brk_wr",  32'(wr_cnt - w0), 32'd24);
    check_val("brk_fd",  32'(fd_cnt - f0), 32'd1);
    check_val("brk_sv",  32'(signal_valid), 32'd1);

    // Release break, then silence: signal_valid must drop on cycle TO.
    bus.rx_break_detect = 1'b0;
    @(posedge CLK_40); #1;
    n_fall = 0;
    for (int k = 1; k <= 3 * TO; k++) begin
      @(posedge CLK_40); #1;
      if (!signal_valid) begin
        n_fall = k;
        break;
      end
    end
    check_val("to_cycles", 32'(n_fall), 32'(TO));
    // Now IDLE: a byte that would be a start code must be ignored.
    w0 = wr_cnt;
    send_byte(8'h42);
    send_slots(3);
    check_val("to_idle_sc", 32'(start_code), 32'h00);
    check_val("to_idle_wr", 32'(wr_cnt - w0), 32'd0);

    // Reset in the middle of a frame.
    w0 = wr_cnt; f0 = fd_cnt;
    do_break();
    send_byte(8'h00);
    send_slots(6);
    reset              = 1'b1;
    bus.rx_data        = 8'd6;
    bus.rx_data_strobe = 1'b1;
    @(posedge CLK_40); #1;
    bus.rx_data_strobe = 1'b0;
    check_val("mrst_we",   32'(bus.slot_we), 32'd0);
    check_val("mrst_addr", 32'(bus.slot_addr), 32'd0);
    check_val("mrst_data", 32'(bus.slot_data), 32'd0);
    check_val("mrst_fsc",  32'(frame_slot_count), 32'd0);
    check_val("mrst_sv",   32'(signal_valid), 32'd0);
    reset = 1'b0;
    @(posedge CLK_40); #1;
    send_byte(8'h00);
    send_slots(5);
    check_val("mrst_wr", 32'(wr_cnt - w0), 32'd6);
    check_val("mrst_fd", 32'(fd_cnt - f0), 32'd0);
    check_val("pulse_width", 32'(dbl_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmx_rx.md
DMX_RX -- requirements
Module: dmx_rx

Interface
REQ-001 Parameter WINDOW, default 256: number of consecutive DMX slots this unit consumes (1..512).
REQ-002 Parameter TIMEOUT_CYCLES, default 40000000: CLK_40 cycles without a received byte or break before the frame is abandoned (1 s).
REQ-003 Parameter TIMEOUT_WIDTH, default 26: width of the timeout counter; SHALL hold TIMEOUT_CYCLES.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 CLK_40  in  1  system clock, 40 MHz.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rx_data  in  8  received byte from the upstream UART.
REQ-008 rx_data_strobe  in  1  one-cycle pulse; rx_data valid this cycle.
REQ-009 rx_break_detect  in  1  level; high while the UART reports a line break.
REQ-010 base_addr  in  9  first DMX slot index (0-based, excluding start code) of the window.
REQ-011 slot_addr  out  9  window-relative slot address (slot index minus latched base).
REQ-012 slot_data  out  8  slot value.
REQ-013 slot_we  out  1  one-cycle write strobe for slot_addr/slot_data.
REQ-014 frame_done  out  1  one-cycle pulse at end of a start-code-0 frame.
REQ-015 frame_slot_count  out  10  slots received in the last completed frame (0..512).
REQ-016 start_code  out  8  start code of the most recent packet.
REQ-017 signal_valid  out  1  high once a valid frame has completed; low after timeout.

Function
REQ-018 States SHALL be IDLE, BREAK, START, SLOTS, SKIP.
REQ-019 In any state, rx_break_detect=1 SHALL move to BREAK next cycle; break wins over a simultaneous rx_data_strobe (byte dropped).
REQ-020 Leaving SLOTS via break or timeout with slot_index>0 SHALL pulse frame_done and latch frame_slot_count=slot_index in the same cycle.
REQ-021 BREAK: when rx_break_detect=0 -> START; timeout counter cleared.
REQ-022 START: on strobe, start_code<=rx_data; rx_data=0x00 -> SLOTS with slot_index=0 and base_addr latched; else -> SKIP.
REQ-023 SLOTS: each strobe SHALL increment slot_index; if latched_base<=slot_index<latched_base+WINDOW and slot_index<=511, slot_we=1 the following cycle with slot_addr=slot_index-latched_base, slot_data=rx_data.
REQ-024 Out-of-window slots SHALL produce no slot_we; window end beyond 511 is clipped, never wrapped.
REQ-025 The 512th slot SHALL write (if in window), pulse frame_done one cycle after its strobe with frame_slot_count=512, and go IDLE.
REQ-026 SKIP: bytes ignored until break or timeout; no frame_done.
REQ-027 IDLE: bytes ignored; only a break leaves IDLE.
REQ-028 Timeout counter SHALL clear on every strobe and while rx_break_detect=1, count in START/SLOTS/SKIP/BREAK, and on reaching TIMEOUT_CYCLES force IDLE and clear signal_valid.
REQ-029 signal_valid SHALL set on every frame_done; frame_done and timeout in the same cycle leaves signal_valid=0.
REQ-030 slot_we and frame_done SHALL never be high for more than one consecutive cycle per event; slot_addr/slot_data hold last value when slot_we=0.

Reset
REQ-031 reset SHALL force IDLE, slot_index=0, timeout counter=0, slot_we=0, frame_done=0, slot_addr=0, slot_data=0, frame_slot_count=0, start_code=0, signal_valid=0.
REQ-032 reset mid-frame SHALL suppress any pending slot_we/frame_done; the next frame is accepted only after a fresh break.

Structure
REQ-033 Package dmx_pkg SHALL hold the state encoding, DMX_MAX_SLOTS=512 and DMX_START_CODE_DIMMER=8'h00.
REQ-034 No sub-module; timeout counter and FSM are inline; the UART is instantiated by the parent.

Verification
REQ-035 Break, start 0x00, 512 bytes value=index[7:0], base_addr=0, WINDOW=256 -> 256 slot_we at addr 0..255, frame_done once, frame_slot_count=512, signal_valid=1.
REQ-036 base_addr=400, WINDOW=256, full frame -> 112 writes, addr 0..111 carrying slots 400..511, no wrap.
REQ-037 Break, start 0x17, 10 bytes -> start_code=0x17, no slot_we, no frame_done.
REQ-038 Start 0x00, 24 bytes, then new break -> frame_done with frame_slot_count=24; strobe coincident with break -> dropped.
REQ-039 Valid frame then silence for TIMEOUT_CYCLES (set to 1000 in bench) -> signal_valid falls at cycle 1000, state IDLE.
REQ-040 reset asserted after slot 5 of a frame -> all outputs zero next cycle; later bytes without break produce no slot_we.
